// File: rtl/ssd_pkg.sv
// Shared constants and state encoding for the seven-segment bus capture block.
package ssd_pkg;

   localparam logic [7:0] BLANK_PATTERN = 8'hFF;
   localparam int         NUM_DIGITS    = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } cap_state_t;

endpackage

// File: rtl/ssd_capture_sync_bus.sv
// Parameterized multi-flop synchronizer for an asynchronous bus; all stages reset to zero.
module sync_bus #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stages [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
      end else begin
         stages[0] <= d;
         for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
   end

   assign q = stages[DEPTH-1];

endmodule

// File: rtl/ssd_capture.sv
// Recovers the four digit bytes from a scanned seven-segment bus and presents them as whole frames.
module ssd_capture
   import ssd_pkg::*;
#(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int SEL_ACTIVE_LOW = 1,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] seven_in,
   input  logic [3:0] segment_in,
   input  logic       clr_err,
   output logic [7:0] disp0,
   output logic [7:0] disp1,
   output logic [7:0] disp2,
   output logic [7:0] disp3,
   output logic       frame_valid,
   output logic       link_alive,
   output logic       err_sel
);

   localparam int STAB_W = $clog2(STABLE_CYCLES);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
   localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);

   logic [NUM_DIGITS-1:0] sel_raw;
   logic [NUM_DIGITS-1:0] sel;
   logic [7:0]            seven;
   logic [NUM_DIGITS+7:0] pair;
   logic [NUM_DIGITS+7:0] prev_pair;
   logic [STAB_W-1:0]     stab_cnt;
   logic [TO_W-1:0]       to_cnt;
   logic [NUM_DIGITS-1:0] seen;
   logic [7:0]            shadow [NUM_DIGITS];
   logic                  pend;
   cap_state_t            state;

   logic changed;
   logic stable;
   logic sel_none;
   logic commit;
   logic err_set;

   // Normalizing before synchronizing makes the zero reset value mean "no digit selected".
   assign sel_raw = (SEL_ACTIVE_LOW != 0) ? ~segment_in : segment_in;

   sync_bus #(.WIDTH(8), .DEPTH(SYNC_STAGES)) u_sync_seven (
      .clk (clk),
      .rst (rst),
      .d   (seven_in),
      .q   (seven)
   );

   sync_bus #(.WIDTH(NUM_DIGITS), .DEPTH(SYNC_STAGES)) u_sync_sel (
      .clk (clk),
      .rst (rst),
      .d   (sel_raw),
      .q   (sel)
   );

   assign pair     = {sel, seven};
   assign changed  = (pair != prev_pair);
   assign stable   = (stab_cnt == STAB_MAX);
   assign sel_none = (sel == '0);
   // A change in the very cycle the count matures still wins, so a one-sample value never commits.
   assign commit   = (state == SETTLE) && !changed && stable && $onehot(sel);
   assign err_set  = (state == SETTLE) && !changed && stable && !sel_none && !$onehot(sel);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_pair <= {{NUM_DIGITS{1'b0}}, BLANK_PATTERN};
         stab_cnt  <= '0;
      end else begin
         prev_pair <= pair;
         if (changed)
            stab_cnt <= '0;
         else if (!stable)
            stab_cnt <= stab_cnt + STAB_W'(1);
      end
   end

   // Capture FSM, shadow frame assembly, timeout watchdog and sticky select error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         seen        <= '0;
         pend        <= 1'b0;
         to_cnt      <= '0;
         disp0       <= BLANK_PATTERN;
         disp1       <= BLANK_PATTERN;
         disp2       <= BLANK_PATTERN;
         disp3       <= BLANK_PATTERN;
         frame_valid <= 1'b0;
         link_alive  <= 1'b0;
         err_sel     <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= BLANK_PATTERN;
      end else begin
         frame_valid <= pend;
         pend        <= 1'b0;
         if (pend) begin
            disp0 <= shadow[0];
            disp1 <= shadow[1];
            disp2 <= shadow[2];
            disp3 <= shadow[3];
         end

         case (state)
            IDLE: begin
               if (!sel_none) state <= SETTLE;
            end
            SETTLE: begin
               if (changed)
                  state <= sel_none ? IDLE : SETTLE;
               else if (stable)
                  state <= HOLD;
            end
            HOLD: begin
               if (changed) state <= sel_none ? IDLE : SETTLE;
            end
            default: state <= IDLE;
         endcase

         if (commit) begin
            for (int i = 0; i < NUM_DIGITS; i++)
               if (sel[i]) shadow[i] <= seven;
            to_cnt     <= '0;
            link_alive <= 1'b1;
            if ((seen | sel) == '1) begin
               seen <= '0;
               pend <= 1'b1;
            end else begin
               seen <= seen | sel;
            end
         end else if (to_cnt == TO_MAX) begin
            link_alive <= 1'b0;
            seen       <= '0;
         end else begin
            to_cnt <= to_cnt + TO_W'(1);
         end

         if (err_set)
            err_sel <= 1'b1;
         else if (clr_err)
            err_sel <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ssd_capture.sv
// Scoreboard bench for ssd_capture: expected frames are queued by the stimulus, a monitor checks each frame_valid.
module tb_ssd_capture;

   logic       clk;
   logic       rst;
   logic [7:0] seven_in;
   logic [3:0] segment_in;
   logic       clr_err;
   logic [7:0] disp0, disp1, disp2, disp3;
   logic       frame_valid;
   logic       link_alive;
   logic       err_sel;

   int total = 0;
   int bad   = 0;
   int frames = 0;
   logic [31:0] expq [$];

   ssd_capture #(
      .STABLE_CYCLES  (4),
      .TIMEOUT_CYCLES (64),
      .SEL_ACTIVE_LOW (1),
      .SYNC_STAGES    (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .seven_in    (seven_in),
      .segment_in  (segment_in),
      .clr_err     (clr_err),
      .disp0       (disp0),
      .disp1       (disp1),
      .disp2       (disp2),
      .disp3       (disp3),
      .frame_valid (frame_valid),
      .link_alive  (link_alive),
      .err_sel     (err_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every frame pulse must match the oldest queued frame, packed as {disp3,disp2,disp1,disp0}.
   always @(negedge clk) begin
      if (rst && frame_valid) begin
         logic [31:0] got;
         logic [31:0] want;
         got = {disp3, disp2, disp1, disp0};
         frames++;
         total++;
         if (expq.size() == 0) begin
            bad++;
            $display("[TB] FAIL frame_unexpected got=%h expected=none", got);
         end else begin
            want = expq.pop_front();
            if (got !== want) begin
               bad++;
               $display("[TB] FAIL frame_data got=%h expected=%h", got, want);
            end
         end
      end
   end

   task automatic applyStimulus(input logic [3:0] sel, input logic [7:0] pat, input int cycles);
      segment_in = sel;
      seven_in   = pat;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s got=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic scanFrame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
      applyStimulus(4'b1110, d0, 8);
      applyStimulus(4'b1101, d1, 8);
      applyStimulus(4'b1011, d2, 8);
      applyStimulus(4'b0111, d3, 8);
      applyStimulus(4'b1111, 8'hFF, 3);
   endtask

   initial begin
      logic saw_err;
      int   frames_before;

      rst        = 1'b0;
      seven_in   = 8'hFF;
      segment_in = 4'b1111;
      clr_err    = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_disp", {disp3, disp2, disp1, disp0}, 32'hFFFF_FFFF);
      checkOutput("reset_flags", {29'd0, frame_valid, link_alive, err_sel}, 32'd0);
      rst = 1'b1;
      applyStimulus(4'b1111, 8'hFF, 3);

      // Test 1: plain scan yields one frame.
      expq.push_back(32'h7856_3412);
      scanFrame(8'h12, 8'h34, 8'h56, 8'h78);
      checkOutput("t1_frames", frames, 1);
      checkOutput("t1_link_alive", {31'd0, link_alive}, 32'd1);

      // Test 2: short glitch value on digit 0 must not be captured.
      expq.push_back(32'h6543_2112);
      applyStimulus(4'b1110, 8'hAA, 3);
      applyStimulus(4'b1110, 8'h12, 8);
      applyStimulus(4'b1101, 8'h21, 8);
      applyStimulus(4'b1011, 8'h43, 8);
      applyStimulus(4'b0111, 8'h65, 8);
      applyStimulus(4'b1111, 8'hFF, 3);
      checkOutput("t2_disp", {disp3, disp2, disp1, disp0}, 32'h6543_2112);

      // Test 3: multi-hot select flags an error and commits nothing.
      applyStimulus(4'b1100, 8'h99, 8);
      applyStimulus(4'b1111, 8'hFF, 2);
      checkOutput("t3_err_set", {31'd0, err_sel}, 32'd1);
      frames_before = frames;
      applyStimulus(4'b1011, 8'h56, 8);
      applyStimulus(4'b0111, 8'h78, 8);
      applyStimulus(4'b1111, 8'hFF, 3);
      checkOutput("t3_no_commit", frames - frames_before, 0);
      checkOutput("t3_err_sticky", {31'd0, err_sel}, 32'd1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      @(negedge clk);
      checkOutput("t3_err_clear", {31'd0, err_sel}, 32'd0);
      clr_err    = 1'b1;
      saw_err    = 1'b0;
      segment_in = 4'b1100;
      seven_in   = 8'h99;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (err_sel) saw_err = 1'b1;
      end
      checkOutput("t3_set_beats_clr", {31'd0, saw_err}, 32'd1);
      applyStimulus(4'b1111, 8'hFF, 2);
      clr_err = 1'b0;
      checkOutput("t3_err_after_clr", {31'd0, err_sel}, 32'd0);
      expq.push_back(32'h7856_B2A1);
      applyStimulus(4'b1110, 8'hA1, 8);
      applyStimulus(4'b1101, 8'hB2, 8);
      applyStimulus(4'b1111, 8'hFF, 1);
      checkOutput("t3_frame_disp", {disp3, disp2, disp1, disp0}, 32'h7856_B2A1);

      // Test 4: frozen blank bus lets the link time out while outputs hold.
      frames_before = frames;
      applyStimulus(4'b1111, 8'hFF, 70);
      checkOutput("t4_link_dead", {31'd0, link_alive}, 32'd0);
      checkOutput("t4_disp_hold", {disp3, disp2, disp1, disp0}, 32'h7856_B2A1);
      checkOutput("t4_no_frame", frames - frames_before, 0);

      // Test 5: reset mid-frame discards the partial capture.
      applyStimulus(4'b1110, 8'hC1, 8);
      applyStimulus(4'b1101, 8'hC2, 8);
      applyStimulus(4'b1011, 8'hC3, 8);
      checkOutput("t5_link_revived", {31'd0, link_alive}, 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("t5_reset_disp", {disp3, disp2, disp1, disp0}, 32'hFFFF_FFFF);
      checkOutput("t5_reset_flags", {29'd0, frame_valid, link_alive, err_sel}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      frames_before = frames;
      applyStimulus(4'b0111, 8'hE4, 8);
      applyStimulus(4'b1011, 8'hE3, 8);
      applyStimulus(4'b1101, 8'hE2, 8);
      applyStimulus(4'b1111, 8'hFF, 3);
      checkOutput("t5_needs_four", frames - frames_before, 0);
      expq.push_back(32'hE4E3_E2E1);
      applyStimulus(4'b1110, 8'hE1, 8);
      applyStimulus(4'b1111, 8'hFF, 3);
      checkOutput("t5_frame", frames - frames_before, 1);

      // Test 6: re-committing digit 0 overwrites it within the same frame.
      frames_before = frames;
      expq.push_back(32'h5544_3322);
      applyStimulus(4'b1110, 8'h11, 8);
      applyStimulus(4'b1110, 8'h22, 8);
      applyStimulus(4'b1101, 8'h33, 8);
      applyStimulus(4'b1011, 8'h44, 8);
      applyStimulus(4'b0111, 8'h55, 8);
      applyStimulus(4'b1111, 8'hFF, 5);
      checkOutput("t6_one_pulse", frames - frames_before, 1);
      checkOutput("t6_disp", {disp3, disp2, disp1, disp0}, 32'h5544_3322);

      checkOutput("queue_drained", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
